// File: rtl/fetch_decode_queue.sv
// Instruction fetch front end: issues 4-byte fetches, queues responses in a FIFO
// and presents the head entry with its RV decode fields.
module fetch_decode_queue #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [4:0]      out_op_class,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  localparam logic [4:0] OPC_LOAD      = 5'h00;
  localparam logic [4:0] OPC_LOAD_FP   = 5'h01;
  localparam logic [4:0] OPC_MISC_MEM  = 5'h03;
  localparam logic [4:0] OPC_OP_IMM    = 5'h04;
  localparam logic [4:0] OPC_AUIPC     = 5'h05;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'h06;
  localparam logic [4:0] OPC_STORE     = 5'h08;
  localparam logic [4:0] OPC_STORE_FP  = 5'h09;
  localparam logic [4:0] OPC_AMO       = 5'h0B;
  localparam logic [4:0] OPC_OP        = 5'h0C;
  localparam logic [4:0] OPC_LUI       = 5'h0D;
  localparam logic [4:0] OPC_OP_32     = 5'h0E;
  localparam logic [4:0] OPC_MADD      = 5'h10;
  localparam logic [4:0] OPC_MSUB      = 5'h11;
  localparam logic [4:0] OPC_NMSUB     = 5'h12;
  localparam logic [4:0] OPC_NMADD     = 5'h13;
  localparam logic [4:0] OPC_OP_FP     = 5'h14;
  localparam logic [4:0] OPC_BRANCH    = 5'h18;
  localparam logic [4:0] OPC_JALR      = 5'h19;
  localparam logic [4:0] OPC_JAL       = 5'h1B;
  localparam logic [4:0] OPC_SYSTEM    = 5'h1C;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            inflight_q, inflight_d;
  logic            inflight_epoch_q, inflight_epoch_d;
  logic            epoch_q, epoch_d;
  logic [XLEN-1:0] ent_pc_q [DEPTH];
  logic [XLEN-1:0] ent_pc_d [DEPTH];
  logic [31:0]     ent_instr_q [DEPTH];
  logic [31:0]     ent_instr_d [DEPTH];

  logic [CW:0]     used;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic [31:0]     head_instr;
  logic [31:0]     imm32;
  logic            legal_op;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The inflight request holds a slot, so a full queue can never receive an unexpected response.
  assign used           = {1'b0, count_q} + (CW + 1)'(inflight_q);
  assign imem_req_valid = !rst && !redirect && (used < (CW + 1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push      = imem_rsp_valid && inflight_q && (inflight_epoch_q == epoch_q)
                     && !redirect && !rst;
  assign out_valid = !rst && (count_q != '0);
  assign pop       = out_valid && out_ready && !redirect;

  always_comb begin
    pc_d             = pc_q;
    rsp_pc_d         = rsp_pc_q;
    count_d          = count_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    inflight_d       = req_fire;
    inflight_epoch_d = epoch_q;
    epoch_d          = epoch_q;
    ent_pc_d         = ent_pc_q;
    ent_instr_d      = ent_instr_q;

    if (req_fire) begin
      pc_d     = pc_q + XLEN'(4);
      rsp_pc_d = pc_q;
    end

    if (push) begin
      ent_pc_d[wr_ptr_q]    = rsp_pc_q;
      ent_instr_d[wr_ptr_q] = imem_rsp_data;
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flipping the epoch orphans anything still outstanding from the old stream.
    if (redirect) begin
      pc_d       = redirect_pc & ALIGN_MASK;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = 1'b0;
      epoch_d    = ~epoch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q             <= RESET_PC & ALIGN_MASK;
      rsp_pc_q         <= '0;
      count_q          <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      rsp_pc_q         <= rsp_pc_d;
      count_q          <= count_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_pc_q    <= ent_pc_d;
    ent_instr_q <= ent_instr_d;
  end

  assign head_instr   = ent_instr_q[rd_ptr_q];
  assign out_pc       = ent_pc_q[rd_ptr_q];
  assign out_instr    = head_instr;
  assign out_op_class = head_instr[6:2];
  assign out_rd       = head_instr[11:7];
  assign out_rs1      = head_instr[19:15];
  assign out_rs2      = head_instr[24:20];
  assign out_funct3   = head_instr[14:12];
  assign out_funct7   = head_instr[31:25];

  always_comb begin
    imm32 = 32'h0;
    case (head_instr[6:2])
      OPC_LOAD, OPC_LOAD_FP, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_SYSTEM:
        imm32 = {{20{head_instr[31]}}, head_instr[31:20]};
      OPC_STORE, OPC_STORE_FP:
        imm32 = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
      OPC_BRANCH:
        imm32 = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                 head_instr[30:25], head_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {head_instr[31:12], 12'h000};
      OPC_JAL:
        imm32 = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                 head_instr[20], head_instr[30:21], 1'b0};
      default:
        imm32 = 32'h0;
    endcase
  end

  assign out_imm = XLEN'($signed(imm32));

  always_comb begin
    legal_op = 1'b0;
    case (head_instr[6:2])
      OPC_LOAD, OPC_LOAD_FP, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32,
      OPC_STORE, OPC_STORE_FP, OPC_AMO, OPC_OP, OPC_LUI, OPC_OP_32,
      OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD, OPC_OP_FP,
      OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM:
        legal_op = 1'b1;
      default:
        legal_op = 1'b0;
    endcase
  end

  assign out_illegal = (head_instr[1:0] != 2'b11) || !legal_op;

endmodule
